// File: rtl/ttt_pixel_gen_pkg.sv
// Shared geometry, cell codes, colours and the stage-1 location record for
// the tic-tac-toe pixel generator.
package ttt_pixel_gen_pkg;

  localparam int PIX_W     = 11;
  localparam int DELTA_W   = 7;
  localparam int NUM_CELLS = 9;

  // Board origin / extent (640x480 mode) and 120-pixel cell boundaries.
  localparam logic [PIX_W-1:0] BOARD_X0 = 11'd160;
  localparam logic [PIX_W-1:0] BOARD_X1 = 11'd519;
  localparam logic [PIX_W-1:0] BOARD_Y0 = 11'd60;
  localparam logic [PIX_W-1:0] BOARD_Y1 = 11'd419;
  localparam logic [PIX_W-1:0] COL1_X   = 11'd280;
  localparam logic [PIX_W-1:0] COL2_X   = 11'd400;
  localparam logic [PIX_W-1:0] ROW1_Y   = 11'd180;
  localparam logic [PIX_W-1:0] ROW2_Y   = 11'd300;

  // Grid lines: 4-pixel bands straddling each internal cell boundary.
  localparam logic [PIX_W-1:0] GRID_X0_LO = 11'd278;
  localparam logic [PIX_W-1:0] GRID_X0_HI = 11'd281;
  localparam logic [PIX_W-1:0] GRID_X1_LO = 11'd398;
  localparam logic [PIX_W-1:0] GRID_X1_HI = 11'd401;
  localparam logic [PIX_W-1:0] GRID_Y0_LO = 11'd178;
  localparam logic [PIX_W-1:0] GRID_Y0_HI = 11'd181;
  localparam logic [PIX_W-1:0] GRID_Y1_LO = 11'd298;
  localparam logic [PIX_W-1:0] GRID_Y1_HI = 11'd301;

  // Cursor border thickness within a cell.
  localparam logic [DELTA_W-1:0] BORDER_LO = 7'd4;
  localparam logic [DELTA_W-1:0] BORDER_HI = 7'd116;

  // X mark: inset box and diagonal half-thickness; anti-diagonal is dx+dy=119.
  localparam logic [DELTA_W-1:0] MARK_LO   = 7'd16;
  localparam logic [DELTA_W-1:0] MARK_HI   = 7'd104;
  localparam logic signed [8:0]  MARK_HALF = 9'sd4;
  localparam logic signed [8:0]  MARK_ANTI = 9'sd119;

  // O mark: ring centred at (60,60), radius 34 (inclusive) to 42 (exclusive).
  localparam logic [DELTA_W-1:0] RING_CTR    = 7'd60;
  localparam logic [12:0]        RING_IN_SQ  = 13'd1156;
  localparam logic [12:0]        RING_OUT_SQ = 13'd1764;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_X     = 2'b01,
    CELL_O     = 2'b10,
    CELL_RSVD  = 2'b11
  } cell_e;

  // Colours as {r,g,b}.
  localparam logic [2:0] RGB_BLACK  = 3'b000;
  localparam logic [2:0] RGB_WHITE  = 3'b111;
  localparam logic [2:0] RGB_YELLOW = 3'b110;
  localparam logic [2:0] RGB_RED    = 3'b100;
  localparam logic [2:0] RGB_BLUE   = 3'b001;
  localparam logic [2:0] RGB_GREEN  = 3'b010;

  typedef struct packed {
    logic               in_board;
    logic [1:0]         col;
    logic [1:0]         row;
    logic [DELTA_W-1:0] dx;
    logic [DELTA_W-1:0] dy;
    logic               grid;
  } loc_t;

  function automatic logic in_range(input logic [PIX_W-1:0] v,
                                    input logic [PIX_W-1:0] lo,
                                    input logic [PIX_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/ttt_cell_locator.sv
// Pipeline stage 1: maps a pixel coordinate to board cell, in-cell offset,
// in-board flag and grid-line flag using comparators and subtractors only.
module ttt_cell_locator
  import ttt_pixel_gen_pkg::*;
(
  input  logic             mclk,
  input  logic             clr_n,
  input  logic [PIX_W-1:0] pixel_x,
  input  logic [PIX_W-1:0] pixel_y,
  output loc_t             loc
);

  loc_t             loc_d;
  logic [PIX_W-1:0] x_base;
  logic [PIX_W-1:0] y_base;

  // Locate the pixel: column/row by threshold compare, offset by subtracting the cell origin.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    loc_d  = '0;
    x_base = BOARD_X0;
    y_base = BOARD_Y0;

    if (pixel_x < COL1_X) begin
      loc_d.col = 2'd0;
    end else if (pixel_x < COL2_X) begin
      loc_d.col = 2'd1;
      x_base    = COL1_X;
    end else begin
      loc_d.col = 2'd2;
      x_base    = COL2_X;
    end

    if (pixel_y < ROW1_Y) begin
      loc_d.row = 2'd0;
    end else if (pixel_y < ROW2_Y) begin
      loc_d.row = 2'd1;
      y_base    = ROW1_Y;
    end else begin
      loc_d.row = 2'd2;
      y_base    = ROW2_Y;
    end

    // Inside the board the offset is 0..119, so the low 7 bits are exact.
    loc_d.dx = 7'(pixel_x - x_base);
    loc_d.dy = 7'(pixel_y - y_base);

    loc_d.in_board = in_range(pixel_x, BOARD_X0, BOARD_X1) &&
                     in_range(pixel_y, BOARD_Y0, BOARD_Y1);
    loc_d.grid     = loc_d.in_board &&
                     (in_range(pixel_x, GRID_X0_LO, GRID_X0_HI) ||
                      in_range(pixel_x, GRID_X1_LO, GRID_X1_HI) ||
                      in_range(pixel_y, GRID_Y0_LO, GRID_Y0_HI) ||
                      in_range(pixel_y, GRID_Y1_LO, GRID_Y1_HI));
  end

  // Stage-1 register.
  always_ff @(posedge mclk or negedge clr_n) begin
    if (!clr_n) begin
      loc <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      loc <= loc_d;
    end
  end

endmodule

// File: rtl/ttt_pixel_gen.sv
// Tic-tac-toe pixel generator: 3-stage pipeline from pixel coordinate to
// 1-bit RGB, with a double-buffered board swapped on vsync rise and a
// frame-counted cursor blink. Sync and vga_on are delayed to match.
module ttt_pixel_gen
  import ttt_pixel_gen_pkg::*;
#(
  parameter int PIPE_LAT     = 3,
  parameter int BLINK_FRAMES = 32
) (
  input  logic             mclk,
  input  logic             clr_n,
  input  logic [PIX_W-1:0] pixel_x,
  input  logic [PIX_W-1:0] pixel_y,
  input  logic             vga_on_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             cell_we,
  input  logic [3:0]       cell_idx,
  input  logic [1:0]       cell_val,
  input  logic             board_clr,
  input  logic [3:0]       cursor_idx,
  input  logic [8:0]       win_mask,
  output logic             rgb_r,
  output logic             rgb_g,
  output logic             rgb_b,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             vga_on_out
);

  localparam int CNT_W = $clog2(BLINK_FRAMES);

  // Sync / active delay lines, oldest bit at the top.
  logic [PIPE_LAT-1:0] hs_d, vs_d, on_d;
  logic                vsync_q;
  logic                vsync_rise;

  // Boards and blink state.
  cell_e             pend_board [NUM_CELLS];
  cell_e             disp_board [NUM_CELLS];
  logic [CNT_W-1:0]  frame_cnt;
  logic              blink_phase;

  // Stage 1 output.
  loc_t              loc;

  // Stage 2 combinational terms and registers.
  logic [3:0]         s1_idx;
  logic               s1_border;
  logic               s1_x_geom;
  logic               s1_o_geom;
  logic signed [8:0]  d_diag;
  logic signed [8:0]  d_anti;
  logic [DELTA_W-1:0] ox, oy;
  logic [11:0]        ox_sq, oy_sq;
  logic [12:0]        r_sq;

  logic  s2_in_board, s2_grid, s2_cursor, s2_x_geom, s2_o_geom, s2_win;
  cell_e s2_cell;

  // Stage 3.
  logic [2:0] rgb_d, rgb_q;

  assign vsync_rise = vsync_in && !vsync_q;

  ttt_cell_locator u_locator (
    .mclk    (mclk),
    .clr_n   (clr_n),
    .pixel_x (pixel_x),
    .pixel_y (pixel_y),
    .loc     (loc)
  );

  // Delay sync and vga_on alongside the pixel pipeline; also track vsync for edge detect.
  always_ff @(posedge mclk or negedge clr_n) begin
    if (!clr_n) begin
      hs_d    <= '0;
      vs_d    <= '0;
      on_d    <= '0;
      vsync_q <= 1'b0;
    end else begin
      hs_d    <= {hs_d[PIPE_LAT-2:0], hsync_in};
      vs_d    <= {vs_d[PIPE_LAT-2:0], vsync_in};
      on_d    <= {on_d[PIPE_LAT-2:0], vga_on_in};
      vsync_q <= vsync_in;
    end
  end

  // Pending board takes game writes; displayed board is refreshed from it on vsync rise.
  always_ff @(posedge mclk or negedge clr_n) begin
    if (!clr_n) begin
      // NOTE: the boards are small flop arrays that must come up empty, so they are reset like any other state.
      for (int i = 0; i < NUM_CELLS; i++) begin
        pend_board[i] <= CELL_EMPTY;
        disp_board[i] <= CELL_EMPTY;
      end
    end else begin
      if (vsync_rise) begin
        for (int i = 0; i < NUM_CELLS; i++) disp_board[i] <= pend_board[i];
      end
      if (board_clr) begin
        for (int i = 0; i < NUM_CELLS; i++) pend_board[i] <= CELL_EMPTY;
      end else if (cell_we && (cell_idx < 4'(NUM_CELLS))) begin
        pend_board[cell_idx] <= cell_e'(cell_val);
      end
    end
  end

  // Frame counter; blink phase flips each time the counter wraps.
  always_ff @(posedge mclk or negedge clr_n) begin
    if (!clr_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (vsync_rise) begin
      frame_cnt <= frame_cnt + 1'b1;
      if (&frame_cnt) blink_phase <= ~blink_phase;
    end
  end

  // Stage-2 geometry: cell index, cursor border, X diagonals and O ring.
  always_comb begin
    s1_idx    = 4'(loc.row) * 4'd3 + 4'(loc.col);
    s1_border = (loc.dx < BORDER_LO) || (loc.dx >= BORDER_HI) ||
                (loc.dy < BORDER_LO) || (loc.dy >= BORDER_HI);

    d_diag    = $signed({2'b00, loc.dx}) - $signed({2'b00, loc.dy});
    d_anti    = $signed({2'b00, loc.dx}) + $signed({2'b00, loc.dy}) - MARK_ANTI;
    s1_x_geom = (loc.dx >= MARK_LO) && (loc.dx < MARK_HI) &&
                (loc.dy >= MARK_LO) && (loc.dy < MARK_HI) &&
                (((d_diag > -MARK_HALF) && (d_diag < MARK_HALF)) ||
                 ((d_anti > -MARK_HALF) && (d_anti < MARK_HALF)));

    ox        = (loc.dx >= RING_CTR) ? (loc.dx - RING_CTR) : (RING_CTR - loc.dx);
    oy        = (loc.dy >= RING_CTR) ? (loc.dy - RING_CTR) : (RING_CTR - loc.dy);
    ox_sq     = 12'(ox) * 12'(ox);
    oy_sq     = 12'(oy) * 12'(oy);
    r_sq      = 13'(ox_sq) + 13'(oy_sq);
    s1_o_geom = (r_sq >= RING_IN_SQ) && (r_sq < RING_OUT_SQ);
  end

  // Stage-2 register: displayed cell code, mark hits, cursor and win hits.
  always_ff @(posedge mclk or negedge clr_n) begin
    if (!clr_n) begin
      s2_in_board <= 1'b0;
      s2_grid     <= 1'b0;
      s2_cursor   <= 1'b0;
      s2_x_geom   <= 1'b0;
      s2_o_geom   <= 1'b0;
      s2_win      <= 1'b0;
      s2_cell     <= CELL_EMPTY;
    end else begin
      s2_in_board <= loc.in_board;
      s2_grid     <= loc.grid;
      s2_cursor   <= blink_phase && s1_border && (cursor_idx < 4'(NUM_CELLS)) &&
                     (cursor_idx == s1_idx);
      s2_x_geom   <= s1_x_geom;
      s2_o_geom   <= s1_o_geom;
      s2_win      <= win_mask[s1_idx];
      s2_cell     <= disp_board[s1_idx];
    end
  end

  // Colour priority: blanking, grid, cursor, X, O, win, background.
  always_comb begin
    rgb_d = RGB_BLACK;
    if (!on_d[1] || !s2_in_board)              rgb_d = RGB_BLACK;
    else if (s2_grid)                          rgb_d = RGB_WHITE;
    else if (s2_cursor)                        rgb_d = RGB_YELLOW;
    else if (s2_cell == CELL_X && s2_x_geom)   rgb_d = RGB_RED;
    else if (s2_cell == CELL_O && s2_o_geom)   rgb_d = RGB_BLUE;
    else if (s2_win)                           rgb_d = RGB_GREEN;
  end

  // Stage-3 register.
  always_ff @(posedge mclk or negedge clr_n) begin
    if (!clr_n) rgb_q <= RGB_BLACK;
    else        rgb_q <= rgb_d;
  end

  assign {rgb_r, rgb_g, rgb_b} = rgb_q;
  assign hsync_out  = hs_d[PIPE_LAT-1];
  assign vsync_out  = vs_d[PIPE_LAT-1];
  assign vga_on_out = on_d[PIPE_LAT-1];

endmodule
